fft_mem_sequencer: RTL and testbench



---
 rtl/fft_mem_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_fft_mem_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mem_sequencer.sv
// fft_mem_sequencer
// Sequences in-place radix-2 DIT FFT passes over the sample RAM. While idle the
// host owns the RAM; while busy the sequencer issues butterfly operand reads
// (A then B), the twiddle index, and replays each read address as a write-back
// after the butterfly pipeline latency. Each stage drains fully before the
// next one starts, so no stage can read a location that is still in flight.
module fft_mem_sequencer #(
  parameter int LOG2N  = 12,
  parameter int BF_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cfg_log2n,
  output logic             busy,
  output logic             done,
  output logic             ram_mode,
  output logic [LOG2N-1:0] rd_adr,
  output logic             rd_valid,
  output logic             rd_sel,
  output logic [LOG2N-2:0] tw_idx,
  output logic [LOG2N-1:0] wr_adr,
  output logic             wr_en,
  output logic [3:0]       stage
);

  localparam int KW = LOG2N - 1;
  localparam int DW = $clog2(BF_LAT + 2);
  localparam int DLY = BF_LAT + 1;
  localparam logic [DW-1:0]    DRAIN_LEN = DW'(BF_LAT + 1);
  localparam logic [DW-1:0]    DRAIN_ONE = DW'(1);
  localparam logic [3:0]       L_MAX     = 4'(LOG2N);
  localparam logic [LOG2N-1:0] ONE       = LOG2N'(1);

  typedef enum logic [2:0] {
    IDLE,
    READ_A,
    READ_B,
    DRAIN,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      l_q, l_d;
  logic [3:0]      s_q, s_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   drain_q, drain_d;

  logic [3:0]       cfg_eff;
  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] adr_a;
  logic [LOG2N-1:0] adr_b;
  logic [KW-1:0]    tw_cur;
  logic [KW-1:0]    k_last;
  logic             last_bf;
  logic             last_stage;

  // Write-back delay line: {valid, address} per slot, oldest in the top slot.
  logic [DLY-1:0][LOG2N:0] dly_q;

  // Clamp the requested size: 0 or anything above the RAM depth means full size.
  always_comb begin
    cfg_eff = cfg_log2n;
    if (cfg_log2n == 4'd0 || cfg_log2n > L_MAX) begin
      cfg_eff = L_MAX;
    end
  end

  // Butterfly address, twiddle and end-of-loop detection for the current (s, k).
  always_comb begin
    k_ext      = LOG2N'(k_q);
    span       = ONE << s_q;
    pos        = k_ext & (span - ONE);
    adr_a      = ((k_ext >> s_q) << (s_q + 4'd1)) | pos;
    adr_b      = adr_a | span;
    tw_cur     = KW'(pos) << (l_q - 4'd1 - s_q);
    k_last     = KW'((ONE << (l_q - 4'd1)) - ONE);
    last_bf    = (k_q == k_last);
    last_stage = (s_q == (l_q - 4'd1));
  end

  // FSM and counter registers; reset aborts any transform immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      l_q     <= 4'd0;
      s_q     <= 4'd0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      l_q     <= l_d;
      s_q     <= s_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: butterfly loop inside a stage, drain, then next stage or finish.
  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    s_d     = s_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          l_d     = cfg_eff;
          s_d     = 4'd0;
          k_d     = '0;
          state_d = READ_A;
        end
      end
      READ_A: begin
        state_d = READ_B;
      end
      READ_B: begin
        if (!last_bf) begin
          k_d     = k_q + KW'(1);
          state_d = READ_A;
        end else begin
          drain_d = DRAIN_LEN;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_ONE) begin
          drain_d = '0;
          if (!last_stage) begin
            s_d     = s_q + 4'd1;
            k_d     = '0;
            state_d = READ_A;
          end else begin
            state_d = FINISH;
          end
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs: RAM ownership, status and the read port for the current state.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    ram_mode = 1'b1;
    rd_valid = 1'b0;
    rd_sel   = 1'b0;
    rd_adr   = '0;
    tw_idx   = '0;
    case (state_q)
      READ_A: begin
        busy     = 1'b1;
        ram_mode = 1'b0;
        rd_valid = 1'b1;
        rd_adr   = adr_a;
        tw_idx   = tw_cur;
      end
      READ_B: begin
        busy     = 1'b1;
        ram_mode = 1'b0;
        rd_valid = 1'b1;
        rd_sel   = 1'b1;
        rd_adr   = adr_b;
        tw_idx   = tw_cur;
      end
      DRAIN: begin
        busy     = 1'b1;
        ram_mode = 1'b0;
      end
      FINISH: begin
        done     = 1'b1;
      end
      default: begin
        busy     = 1'b0;
      end
    endcase
  end

  // Shift each read request down the delay line so it returns as a write-back
  // exactly BF_LAT+1 cycles later; clearing it on reset cancels pending writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= {rd_valid, rd_adr};
      for (int i = 1; i < DLY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign wr_en  = dly_q[DLY-1][LOG2N];
  assign wr_adr = dly_q[DLY-1][LOG2N-1:0];
  assign stage  = s_q;

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Directed self-checking bench for fft_mem_sequencer (LOG2N=12, BF_LAT=4).
module tb_fft_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_log2n = 4'd0;
  logic        busy, done, ram_mode, rd_valid, rd_sel, wr_en;
  logic [11:0] rd_adr, wr_adr;
  logic [10:0] tw_idx;
  logic [3:0]  stage;

  int errors = 0;
  int checks = 0;

  bit pending [4096];
  bit seen    [4096];

  fft_mem_sequencer #(.LOG2N(12), .BF_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_log2n(cfg_log2n),
    .busy(busy), .done(done), .ram_mode(ram_mode),
    .rd_adr(rd_adr), .rd_valid(rd_valid), .rd_sel(rd_sel), .tw_idx(tw_idx),
    .wr_adr(wr_adr), .wr_en(wr_en), .stage(stage)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Pulse start for one cycle; returns at the negedge of the first busy cycle.
  task automatic do_start(input logic [3:0] c);
    @(negedge clk);
    cfg_log2n = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, ram_mode, rd_valid, wr_en} !== 5'b00100)
      begin errors++; $display("[TB] FAIL reset_held: got %b expected 00100", {busy, done, ram_mode, rd_valid, wr_en}); end
    rst = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ram_mode, rd_valid, wr_en, rd_sel} !== 6'b001000 || rd_adr !== 12'd0 || wr_adr !== 12'd0 || tw_idx !== 11'd0 || stage !== 4'd0)
      begin errors++; $display("[TB] FAIL reset_pulse: flags=%b rd=%0d wr=%0d tw=%0d st=%0d", {busy, done, ram_mode, rd_valid, wr_en, rd_sel}, rd_adr, wr_adr, tw_idx, stage); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, ram_mode, rd_valid, wr_en} !== 5'b00100)
      begin errors++; $display("[TB] FAIL reset_release: got %b expected 00100", {busy, done, ram_mode, rd_valid, wr_en}); end
  endtask

  // L=2: full cycle-by-cycle check of reads, twiddles, write-backs and stage.
  task automatic test_l2_vectors;
    int exp_adr [8] = '{0, 1, 2, 3, 0, 2, 1, 3};
    int exp_tw  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    int cyc, ri, wi, wc;
    do_start(4'd2);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      ri = -1;
      if (cyc < 4) ri = cyc;
      else if (cyc >= 9 && cyc < 13) ri = cyc - 5;
      wc = cyc - 5;
      wi = -1;
      if (wc >= 0 && wc < 4) wi = wc;
      else if (wc >= 9 && wc < 13) wi = wc - 5;
      checks++;
      if (rd_valid !== (ri >= 0))
        begin errors++; $display("[TB] FAIL l2_rd_valid c%0d: got %b expected %b", cyc, rd_valid, ri >= 0); end
      if (ri >= 0) begin
        checks++;
        if (rd_adr !== 12'(exp_adr[ri]) || rd_sel !== ri[0] || tw_idx !== 11'(exp_tw[ri]))
          begin errors++; $display("[TB] FAIL l2_read c%0d: adr=%0d sel=%b tw=%0d expected adr=%0d sel=%b tw=%0d", cyc, rd_adr, rd_sel, tw_idx, exp_adr[ri], ri[0], exp_tw[ri]); end
      end
      checks++;
      if (wr_en !== (wi >= 0))
        begin errors++; $display("[TB] FAIL l2_wr_en c%0d: got %b expected %b", cyc, wr_en, wi >= 0); end
      if (wi >= 0) begin
        checks++;
        if (wr_adr !== 12'(exp_adr[wi]))
          begin errors++; $display("[TB] FAIL l2_wr_adr c%0d: got %0d expected %0d", cyc, wr_adr, exp_adr[wi]); end
      end
      checks++;
      if (stage !== ((cyc < 9) ? 4'd0 : 4'd1))
        begin errors++; $display("[TB] FAIL l2_stage c%0d: got %0d expected %0d", cyc, stage, (cyc < 9) ? 0 : 1); end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 18)
      begin errors++; $display("[TB] FAIL l2_busy_cycles: got %0d expected 18", cyc); end
    checks++;
    if (done !== 1'b1 || ram_mode !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL l2_finish: done=%b ram_mode=%b busy=%b expected 1 1 0", done, ram_mode, busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ram_mode !== 1'b1)
      begin errors++; $display("[TB] FAIL l2_after_done: done=%b busy=%b ram_mode=%b expected 0 0 1", done, busy, ram_mode); end
  endtask

  // Full-size transform: cycle count, write count, write-once per stage, no RAW hazard.
  task automatic test_l12_full;
    int cnt, wr_total, stage_wr, dup, hazard;
    logic [3:0] prev_stage;
    do_start(4'd12);
    cnt = 0; wr_total = 0; stage_wr = 0; dup = 0; hazard = 0;
    prev_stage = stage;
    while (busy === 1'b1 && cnt < 60000) begin
      if (stage !== prev_stage) begin
        checks++;
        if (stage_wr !== 4096)
          begin errors++; $display("[TB] FAIL l12_stage_writes s%0d: got %0d expected 4096", prev_stage, stage_wr); end
        stage_wr = 0;
        for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
        prev_stage = stage;
      end
      if (rd_valid === 1'b1) begin
        if (pending[rd_adr]) hazard++;
        pending[rd_adr] = 1'b1;
      end
      if (wr_en === 1'b1) begin
        wr_total++;
        stage_wr++;
        if (seen[wr_adr]) dup++;
        seen[wr_adr] = 1'b1;
        pending[wr_adr] = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== 49212)
      begin errors++; $display("[TB] FAIL l12_busy_cycles: got %0d expected 49212", cnt); end
    checks++;
    if (wr_total !== 49152)
      begin errors++; $display("[TB] FAIL l12_wr_total: got %0d expected 49152", wr_total); end
    checks++;
    if (stage_wr !== 4096 || prev_stage !== 4'd11)
      begin errors++; $display("[TB] FAIL l12_last_stage: writes=%0d stage=%0d expected 4096 11", stage_wr, prev_stage); end
    checks++;
    if (dup !== 0)
      begin errors++; $display("[TB] FAIL l12_write_once: dup=%0d expected 0", dup); end
    checks++;
    if (hazard !== 0)
      begin errors++; $display("[TB] FAIL l12_hazard: got %0d expected 0", hazard); end
    checks++;
    if (done !== 1'b1)
      begin errors++; $display("[TB] FAIL l12_done: got %b expected 1", done); end
    @(negedge clk);
  endtask

  // Out-of-range size: stage 0 must last 4096 reads + 5 drain cycles (L=12), then abort.
  task automatic test_cfg_clamp(input logic [3:0] c);
    int cnt;
    do_start(c);
    cnt = 0;
    while (busy === 1'b1 && stage === 4'd0 && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt !== 4101 || stage !== 4'd1 || busy !== 1'b1)
      begin errors++; $display("[TB] FAIL clamp_cfg%0d: stage0 cycles=%0d stage=%0d busy=%b expected 4101 1 1", c, cnt, stage, busy); end
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ram_mode !== 1'b1)
      begin errors++; $display("[TB] FAIL clamp_abort_cfg%0d: busy=%b ram_mode=%b expected 0 1", c, busy, ram_mode); end
  endtask

  task automatic test_start_ignored;
    int cnt, extra;
    do_start(4'd2);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      start = (cnt == 3 || cnt == 10);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (cnt !== 18 || done !== 1'b1)
      begin errors++; $display("[TB] FAIL repulse_cycles: got %0d done=%b expected 18 1", cnt, done); end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0)
      begin errors++; $display("[TB] FAIL repulse_restart: busy cycles=%0d expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    int cnt, gap;
    @(negedge clk);
    cfg_log2n = 4'd2;
    start = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt !== 18 || done !== 1'b1)
      begin errors++; $display("[TB] FAIL b2b_first: cycles=%0d done=%b expected 18 1", cnt, done); end
    gap = 0;
    while (busy !== 1'b1 && gap < 4) begin @(negedge clk); gap++; end
    start = 1'b0;
    checks++;
    if (gap < 1 || gap > 2)
      begin errors++; $display("[TB] FAIL b2b_gap: got %0d expected 1..2", gap); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt !== 18 || done !== 1'b1)
      begin errors++; $display("[TB] FAIL b2b_second: cycles=%0d done=%b expected 18 1", cnt, done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int cnt, wcnt;
    bit found;
    do_start(4'd4);
    cnt = 0; found = 1'b0;
    while (cnt < 200 && !found) begin
      if (stage === 4'd3 && rd_valid === 1'b1 && rd_sel === 1'b1) found = 1'b1;
      else begin @(negedge clk); cnt++; end
    end
    checks++;
    if (!found)
      begin errors++; $display("[TB] FAIL midrst_reach: stage3 READ_B seen=%b expected 1", found); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ram_mode, rd_valid, wr_en, rd_sel} !== 6'b001000 || rd_adr !== 12'd0 || wr_adr !== 12'd0 || tw_idx !== 11'd0 || stage !== 4'd0)
      begin errors++; $display("[TB] FAIL midrst_async: flags=%b rd=%0d wr=%0d tw=%0d st=%0d", {busy, done, ram_mode, rd_valid, wr_en, rd_sel}, rd_adr, wr_adr, tw_idx, stage); end
    wcnt = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (wr_en !== 1'b0) wcnt++; end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (wr_en !== 1'b0 || busy !== 1'b0) wcnt++; end
    checks++;
    if (wcnt !== 0)
      begin errors++; $display("[TB] FAIL midrst_no_write: got %0d active cycles expected 0", wcnt); end
    do_start(4'd3);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt !== 39 || done !== 1'b1)
      begin errors++; $display("[TB] FAIL midrst_l3_run: cycles=%0d done=%b expected 39 1", cnt, done); end
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting fft_mem_sequencer bench");
    test_reset();
    test_l2_vectors();
    test_l12_full();
    test_cfg_clamp(4'd0);
    test_cfg_clamp(4'd15);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
